// File: rtl/buffer_tile_reader.sv
// buffer_tile_reader
//   Read-side sequencer for buffer_file. A start pulse launches a run of N
//   consecutive tile reads from one buffer, always beginning at tile 0. Each
//   tile is presented on a valid/ready output port.
//
//   Handshake: a tile transfers in any cycle where tile_valid && tile_ready
//   at the rising clock edge. Once tile_valid is raised, tile_data,
//   tile_index and tile_last stay stable and tile_valid stays high until
//   that transfer happens.
//
//   Ports
//     clk, reset_n              clock, asynchronous active-low reset
//     start, buf_sel, num_tiles run request. Sampled only while idle.
//                               num_tiles of 0, or above TILE_COUNT, means
//                               TILE_COUNT tiles.
//     busy, done                run in progress / one-cycle completion pulse
//     buf_read_*                read strobe and buffer select to buffer_file
//     buf_reset_indices_*       read-index reset to buffer_file. Raised on
//                               the first read of a run only.
//     buf_read_data             tile data from buffer_file, valid in CAPTURE
//     buf_reading_done          buffer_file end-of-buffer flag
//     tile_valid/ready/data/index/last   output tile stream
//     err                       sticky buffer/index consistency error
//
//   Configuration macro: TILE_READER_CHECK_EN. When it is defined,
//   buf_reading_done is checked against the tile index. When it is
//   undefined, err is tied to 0.
//
//   Parameter defaults mirror accelerator_config_pkg: 8-bit elements,
//   4 elements per tile, 4 tiles per buffer.
module buffer_tile_reader #(
   parameter int DATA_WIDTH   = 8,
   parameter int TILE_SIZE    = 4,
   parameter int TILE_WIDTH   = TILE_SIZE * DATA_WIDTH,
   parameter int BUFFER_WIDTH = 4 * TILE_WIDTH,
   parameter int BUFFER_COUNT = 2,
   localparam int TILE_COUNT  = BUFFER_WIDTH / TILE_WIDTH,
   localparam int CW          = $clog2(TILE_COUNT + 1),
   localparam int BW          = $clog2(BUFFER_COUNT)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [BW-1:0]         buf_sel,
   input  logic [CW-1:0]         num_tiles,
   output logic                  busy,
   output logic                  done,
   output logic                  buf_read_enable,
   output logic [BW-1:0]         buf_read_buffer,
   output logic                  buf_reset_indices_enable,
   output logic [BW-1:0]         buf_reset_indices_buffer,
   input  logic [DATA_WIDTH-1:0] buf_read_data [0:TILE_SIZE-1],
   input  logic                  buf_reading_done,
   output logic                  tile_valid,
   input  logic                  tile_ready,
   output logic [DATA_WIDTH-1:0] tile_data [0:TILE_SIZE-1],
   output logic [CW-1:0]         tile_index,
   output logic                  tile_last,
   output logic                  err
);

   localparam logic [CW-1:0] TC    = CW'(TILE_COUNT);
   localparam logic [CW-1:0] TC_M1 = CW'(TILE_COUNT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_CAPTURE,
      ST_HOLD
   } state_t;

   state_t                state_q, state_d;
   logic [BW-1:0]         sel_q, sel_d;
   logic [CW-1:0]         n_q, n_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  first_q, first_d;
   logic                  done_q, done_d;
   logic                  valid_q, valid_d;
   logic                  last_q, last_d;
   logic [CW-1:0]         idx_q, idx_d;
   logic [DATA_WIDTH-1:0] data_q [0:TILE_SIZE-1];
   logic [DATA_WIDTH-1:0] data_d [0:TILE_SIZE-1];

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      done_d  = 1'b0;
      valid_d = valid_q;
      last_d  = last_q;
      idx_d   = idx_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               sel_d   = buf_sel;
               n_d     = (num_tiles == '0 || num_tiles > TC) ? TC : num_tiles;
               cnt_d   = '0;
               first_d = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            first_d = 1'b0;
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            data_d  = buf_read_data;
            idx_d   = cnt_q;
            last_d  = (cnt_q == n_q - CW'(1));
            valid_d = 1'b1;
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (valid_q && tile_ready) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               cnt_d   = cnt_q + CW'(1);
               if (last_q) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         n_q     <= '0;
         cnt_q   <= '0;
         first_q <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         idx_q   <= '0;
         for (int i = 0; i < TILE_SIZE; i++) data_q[i] <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
      end
   end

`ifdef TILE_READER_CHECK_EN
   // In CAPTURE, buf_reading_done reflects the read issued in the previous
   // cycle. It must be high exactly when that read hit the last tile.
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (state_q == ST_IDLE && start) begin
         err_d = 1'b0;
      end else if (state_q == ST_CAPTURE && (buf_reading_done != (cnt_q == TC_M1))) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) err_q <= 1'b0;
      else          err_q <= err_d;
   end

   assign err = err_q;
`else
   logic unused_reading_done;
   assign unused_reading_done = buf_reading_done ^ (TC_M1 == '0);
   assign err = 1'b0;
`endif

   // The buffer's strobes are decoded from state alone. This keeps them
   // glitch-free, and ISSUE never repeats back to back, so buffer_file
   // always sees a low gap before the next rising edge.
   assign busy                     = (state_q != ST_IDLE);
   assign done                     = done_q;
   assign buf_read_enable          = (state_q == ST_ISSUE);
   assign buf_reset_indices_enable = (state_q == ST_ISSUE) && first_q;
   assign buf_read_buffer          = busy ? sel_q : '0;
   assign buf_reset_indices_buffer = busy ? sel_q : '0;
   assign tile_valid               = valid_q;
   assign tile_data                = data_q;
   assign tile_index               = idx_q;
   assign tile_last                = last_q;

endmodule

// File: tb/tb_buffer_tile_reader.sv
module tb_buffer_tile_reader;
   localparam int DW = 8;
   localparam int TS = 4;
   localparam int TC = 4;
   localparam int CW = 3;
   localparam int BW = 1;
   localparam int TW = DW * TS;

   // clock / reset
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic          start = 1'b0;
   logic [BW-1:0] buf_sel = '0;
   logic [CW-1:0] num_tiles = '0;
   logic          busy, done;
   logic          buf_read_enable, buf_reset_indices_enable;
   logic [BW-1:0] buf_read_buffer, buf_reset_indices_buffer;
   logic [DW-1:0] buf_read_data [0:TS-1];
   logic          buf_reading_done;
   logic          tile_valid;
   logic          tile_ready = 1'b1;
   logic [DW-1:0] tile_data [0:TS-1];
   logic [CW-1:0] tile_index;
   logic          tile_last;
   logic          err;

   buffer_tile_reader #(
      .DATA_WIDTH(DW), .TILE_SIZE(TS), .TILE_WIDTH(TW),
      .BUFFER_WIDTH(TC * TW), .BUFFER_COUNT(2)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .buf_sel(buf_sel),
      .num_tiles(num_tiles), .busy(busy), .done(done),
      .buf_read_enable(buf_read_enable), .buf_read_buffer(buf_read_buffer),
      .buf_reset_indices_enable(buf_reset_indices_enable),
      .buf_reset_indices_buffer(buf_reset_indices_buffer),
      .buf_read_data(buf_read_data), .buf_reading_done(buf_reading_done),
      .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_data(tile_data),
      .tile_index(tile_index), .tile_last(tile_last), .err(err)
   );

   // behavioural buffer_file: per-buffer read index, edge-triggered read,
   // registered data and end-of-buffer flag
   logic [TW-1:0] mem [0:1][0:TC-1];
   int            ridx [0:1];
   logic [TW-1:0] rd_q = '0;
   logic          rdone_q = 1'b0;
   int            last_rd_idx = -1;
   logic          re_prev = 1'b0;
   bit            force_en = 1'b0;
   int            mb, mk;

   always @(posedge clk) begin
      if (buf_read_enable && !re_prev) begin
         mb = int'(buf_read_buffer);
         mk = (buf_reset_indices_enable && buf_reset_indices_buffer == buf_read_buffer) ? 0 : ridx[mb];
         rd_q        <= mem[mb][mk];
         rdone_q     <= (mk == TC - 1);
         last_rd_idx <= mk;
         ridx[mb]    <= (mk + 1) % TC;
      end
      re_prev <= buf_read_enable;
   end

   always_comb begin
      for (int i = 0; i < TS; i++) buf_read_data[i] = rd_q[i*DW +: DW];
      buf_reading_done = rdone_q | (force_en && last_rd_idx == 1);
   end

   // scoreboard
   int total = 0;
   int bad = 0;
   logic [TW-1:0] exp_q[$];
   logic [TW-1:0] obs_data[$];
   int            obs_idx[$];
   bit            obs_last[$];
   int  re_pulses, re_consec, rst_pulses, rst_late, sel_bad, stable_bad;
   int  done_cyc, first_busy, first_valid;
   bit  busy_at_done, err_c1, err_end;

   function automatic logic [TW-1:0] pack_tile();
      logic [TW-1:0] v;
      for (int i = 0; i < TS; i++) v[i*DW +: DW] = tile_data[i];
      return v;
   endfunction

   function automatic int n_eff(input int num);
      return (num == 0 || num > TC) ? TC : num;
   endfunction

   // reference model: a run reads tiles 0..N-1 of the selected buffer
   task automatic build_exp(input int sel, input int num);
      exp_q.delete();
      for (int k = 0; k < n_eff(num); k++) exp_q.push_back(mem[sel][k]);
   endtask

   // driver/collector: issues one run and records what the DUT does
   task automatic run_op(input int sel, input int num, input int stall_tile,
                         input int stall_len, input int inj_cyc, input bit rand_ready);
      logic [TW-1:0] snap_data;
      logic [CW-1:0] snap_idx;
      bit snap_ok, prev_re;
      int stall_left;
      obs_data.delete(); obs_idx.delete(); obs_last.delete();
      re_pulses = 0; re_consec = 0; rst_pulses = 0; rst_late = 0;
      sel_bad = 0; stable_bad = 0; done_cyc = 0; first_busy = 0; first_valid = 0;
      busy_at_done = 1'b1; err_c1 = 1'b1; err_end = 1'b1;
      snap_ok = 1'b0; prev_re = 1'b0; stall_left = stall_len;
      snap_data = '0; snap_idx = '0;
      buf_sel = BW'(sel); num_tiles = CW'(num); start = 1'b1;
      tile_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == inj_cyc) begin
            start = 1'b1; buf_sel = BW'(~sel); num_tiles = CW'(1);
         end
         if (c == 1) err_c1 = err;
         if (busy && first_busy == 0) first_busy = c;
         if (tile_valid && first_valid == 0) first_valid = c;
         if (buf_read_enable) begin
            re_pulses++;
            if (prev_re) re_consec++;
         end
         prev_re = buf_read_enable;
         if (buf_reset_indices_enable) begin
            rst_pulses++;
            if (obs_data.size() != 0) rst_late++;
         end
         if (busy && (buf_read_buffer != BW'(sel) || buf_reset_indices_buffer != BW'(sel))) sel_bad++;
         if (done) begin
            done_cyc = c; busy_at_done = busy; err_end = err;
            break;
         end
         if (tile_valid) begin
            if (obs_data.size() == stall_tile && stall_len > 0) begin
               if (!snap_ok) begin
                  snap_data = pack_tile(); snap_idx = tile_index; snap_ok = 1'b1;
               end else if (pack_tile() !== snap_data || tile_index !== snap_idx) begin
                  stable_bad++;
               end
            end
            if (obs_data.size() == stall_tile && stall_left > 0) begin
               tile_ready = 1'b0; stall_left--;
            end else begin
               tile_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (tile_ready) begin
               obs_data.push_back(pack_tile());
               obs_idx.push_back(int'(tile_index));
               obs_last.push_back(tile_last);
            end
         end else begin
            tile_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
      tile_ready = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({busy, done, tile_valid, tile_last, buf_read_enable, buf_reset_indices_enable, err} !== 7'b0) begin
         bad++; $display("FAIL reset_flags got=%b exp=0", {busy, done, tile_valid, tile_last, buf_read_enable, buf_reset_indices_enable, err});
      end
      total++;
      if (pack_tile() !== '0 || tile_index !== '0 || buf_read_buffer !== '0 || buf_reset_indices_buffer !== '0) begin
         bad++; $display("FAIL reset_values got=%h/%0d/%0d/%0d exp=0", pack_tile(), tile_index, buf_read_buffer, buf_reset_indices_buffer);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_full_read();
      build_exp(1, 0);
      run_op(1, 0, -1, 0, 0, 1'b0);
      total++;
      if (done_cyc !== 13) begin bad++; $display("FAIL full_done_cycle got=%0d exp=13", done_cyc); end
      total++;
      if (first_busy !== 1 || first_valid !== 3) begin
         bad++; $display("FAIL full_latency got=busy@%0d valid@%0d exp=busy@1 valid@3", first_busy, first_valid);
      end
      total++;
      if (obs_data.size() !== exp_q.size()) begin bad++; $display("FAIL full_count got=%0d exp=%0d", obs_data.size(), exp_q.size()); end
      foreach (exp_q[k]) if (k < obs_data.size()) begin
         total++;
         if (obs_data[k] !== exp_q[k] || obs_idx[k] !== k || obs_last[k] !== (k == exp_q.size() - 1)) begin
            bad++; $display("FAIL full_tile%0d got=%h/%0d/%b exp=%h/%0d/%b", k, obs_data[k], obs_idx[k], obs_last[k], exp_q[k], k, k == exp_q.size() - 1);
         end
      end
      total++;
      if (re_pulses !== 4 || re_consec !== 0 || rst_pulses !== 1 || sel_bad !== 0) begin
         bad++; $display("FAIL full_strobes got=re%0d cons%0d rst%0d selbad%0d exp=re4 cons0 rst1 selbad0", re_pulses, re_consec, rst_pulses, sel_bad);
      end
      total++;
      if (busy_at_done !== 1'b0 || err_end !== 1'b0) begin
         bad++; $display("FAIL full_end got=busy%b err%b exp=busy0 err0", busy_at_done, err_end);
      end
   endtask

   task automatic test_stall();
      build_exp(0, 4);
      run_op(0, 4, 1, 5, 0, 1'b0);
      total++;
      if (stable_bad !== 0) begin bad++; $display("FAIL stall_stable got=%0d exp=0", stable_bad); end
      total++;
      if (re_pulses !== 4 || done_cyc !== 18) begin
         bad++; $display("FAIL stall_timing got=re%0d done@%0d exp=re4 done@18", re_pulses, done_cyc);
      end
      total++;
      if (obs_data.size() !== 4) begin bad++; $display("FAIL stall_count got=%0d exp=4", obs_data.size()); end
      foreach (exp_q[k]) if (k < obs_data.size()) begin
         total++;
         if (obs_data[k] !== exp_q[k] || obs_idx[k] !== k) begin
            bad++; $display("FAIL stall_tile%0d got=%h/%0d exp=%h/%0d", k, obs_data[k], obs_idx[k], exp_q[k], k);
         end
      end
   endtask

   task automatic test_partial_then_full();
      build_exp(0, 2);
      run_op(0, 2, -1, 0, 0, 1'b0);
      total++;
      if (obs_data.size() !== 2 || done_cyc !== 7 || obs_last[1] !== 1'b1) begin
         bad++; $display("FAIL partial_run got=n%0d done@%0d exp=n2 done@7", obs_data.size(), done_cyc);
      end
      build_exp(0, 4);
      run_op(0, 4, -1, 0, 0, 1'b0);
      total++;
      if (rst_pulses !== 1 || rst_late !== 0) begin
         bad++; $display("FAIL rerun_reset_idx got=rst%0d late%0d exp=rst1 late0", rst_pulses, rst_late);
      end
      total++;
      if (obs_data.size() !== 4) begin bad++; $display("FAIL rerun_count got=%0d exp=4", obs_data.size()); end
      foreach (exp_q[k]) if (k < obs_data.size()) begin
         total++;
         if (obs_data[k] !== exp_q[k] || obs_idx[k] !== k) begin
            bad++; $display("FAIL rerun_tile%0d got=%h/%0d exp=%h/%0d", k, obs_data[k], obs_idx[k], exp_q[k], k);
         end
      end
   endtask

   task automatic test_start_while_busy();
      build_exp(1, 3);
      run_op(1, 3, -1, 0, 4, 1'b0);
      total++;
      if (sel_bad !== 0 || obs_data.size() !== 3 || done_cyc !== 10) begin
         bad++; $display("FAIL busy_start got=selbad%0d n%0d done@%0d exp=selbad0 n3 done@10", sel_bad, obs_data.size(), done_cyc);
      end
      foreach (exp_q[k]) if (k < obs_data.size()) begin
         total++;
         if (obs_data[k] !== exp_q[k] || obs_last[k] !== (k == 2)) begin
            bad++; $display("FAIL busy_tile%0d got=%h/%b exp=%h/%b", k, obs_data[k], obs_last[k], exp_q[k], k == 2);
         end
      end
   endtask

   task automatic test_clamp();
      build_exp(1, 7);
      run_op(1, 7, -1, 0, 0, 1'b0);
      total++;
      if (obs_data.size() !== TC || done_cyc !== 13) begin
         bad++; $display("FAIL clamp got=n%0d done@%0d exp=n%0d done@13", obs_data.size(), done_cyc, TC);
      end
      total++;
      if (obs_data.size() == TC && (obs_data[3] !== exp_q[3] || obs_last[3] !== 1'b1)) begin
         bad++; $display("FAIL clamp_last got=%h/%b exp=%h/1", obs_data[3], obs_last[3], exp_q[3]);
      end
   endtask

   task automatic test_reset_mid();
      bit seen = 1'b0;
      buf_sel = 1'b1; num_tiles = CW'(4); start = 1'b1; tile_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (tile_valid) seen = 1'b1;
      end
      total++;
      if (!seen) begin bad++; $display("FAIL rstmid_wait got=no_valid exp=valid"); end
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({busy, tile_valid, buf_read_enable, tile_last} !== 4'b0 || buf_read_buffer !== '0) begin
         bad++; $display("FAIL rstmid_async got=%b sel%0d exp=0000 sel0", {busy, tile_valid, buf_read_enable, tile_last}, buf_read_buffer);
      end
      @(negedge clk);
      reset_n = 1'b1; tile_ready = 1'b1;
      @(negedge clk);
      build_exp(1, 4);
      run_op(1, 4, -1, 0, 0, 1'b0);
      total++;
      if (obs_data.size() !== 4 || done_cyc !== 13) begin
         bad++; $display("FAIL rstmid_rerun got=n%0d done@%0d exp=n4 done@13", obs_data.size(), done_cyc);
      end
      foreach (exp_q[k]) if (k < obs_data.size()) begin
         total++;
         if (obs_data[k] !== exp_q[k]) begin
            bad++; $display("FAIL rstmid_tile%0d got=%h exp=%h", k, obs_data[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_err();
      bit exp_err;
`ifdef TILE_READER_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      force_en = 1'b1;
      build_exp(0, 4);
      run_op(0, 4, -1, 0, 0, 1'b0);
      force_en = 1'b0;
      total++;
      if (err_end !== exp_err || err !== exp_err) begin
         bad++; $display("FAIL err_set got=%b/%b exp=%b", err_end, err, exp_err);
      end
      total++;
      if (obs_data.size() !== 4 || done_cyc !== 13) begin
         bad++; $display("FAIL err_flow got=n%0d done@%0d exp=n4 done@13", obs_data.size(), done_cyc);
      end
      foreach (exp_q[k]) if (k < obs_data.size()) begin
         total++;
         if (obs_data[k] !== exp_q[k]) begin
            bad++; $display("FAIL err_tile%0d got=%h exp=%h", k, obs_data[k], exp_q[k]);
         end
      end
      run_op(1, 1, -1, 0, 0, 1'b0);
      total++;
      if (err_c1 !== 1'b0 || err_end !== 1'b0) begin
         bad++; $display("FAIL err_clear got=%b/%b exp=0/0", err_c1, err_end);
      end
   endtask

   task automatic test_random();
      int sel, num;
      for (int it = 0; it < 8; it++) begin
         sel = $urandom_range(0, 1);
         num = $urandom_range(0, 7);
         build_exp(sel, num);
         run_op(sel, num, -1, 0, 0, 1'b1);
         total++;
         if (done_cyc == 0 || obs_data.size() !== exp_q.size() || re_consec !== 0 || sel_bad !== 0) begin
            bad++; $display("FAIL rand%0d_run got=done@%0d n%0d cons%0d selbad%0d exp=n%0d", it, done_cyc, obs_data.size(), re_consec, sel_bad, exp_q.size());
         end
         foreach (exp_q[k]) if (k < obs_data.size()) begin
            total++;
            if (obs_data[k] !== exp_q[k] || obs_idx[k] !== k || obs_last[k] !== (k == exp_q.size() - 1)) begin
               bad++; $display("FAIL rand%0d_tile%0d got=%h/%0d/%b exp=%h/%0d", it, k, obs_data[k], obs_idx[k], obs_last[k], exp_q[k], k);
            end
         end
      end
   endtask

   initial begin
      for (int b = 0; b < 2; b++) begin
         ridx[b] = 0;
         for (int k = 0; k < TC; k++) mem[b][k] = $urandom;
      end
      test_reset();
      test_full_read();
      test_stall();
      test_partial_then_full();
      test_start_while_busy();
      test_clamp();
      test_reset_mid();
      test_err();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
